// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit: radix-2^MUL_BITS shift-add
// multiply, restoring divide, valid/ready issue and retire, flush via kill.
module muldiv_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 1,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int unsigned PW        = XLEN + MUL_BITS;
  localparam int unsigned MUL_STEPS = XLEN / MUL_BITS;
  localparam int unsigned CNT_W     = $clog2(XLEN + 1);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [2:0]       op;
  logic [TAG_W-1:0] tag_q;
  logic             neg;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  mcand;
  logic [CNT_W-1:0] cnt;

  // Operand decode: magnitudes, result sign and the two divide special cases
  logic            signed_a_c, signed_b_c, sa_c, sb_c;
  logic            div_zero_c, div_ovf_c, neg_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;

  always_comb begin
    signed_a_c = (funct3 != F_MULHU) && (funct3 != F_DIVU) && (funct3 != F_REMU);
    signed_b_c = signed_a_c && (funct3 != F_MULHSU);
    sa_c       = signed_a_c & rs1[XLEN-1];
    sb_c       = signed_b_c & rs2[XLEN-1];
    mag_a_c    = sa_c ? -rs1 : rs1;
    mag_b_c    = sb_c ? -rs2 : rs2;
    div_zero_c = funct3[2] && (rs2 == '0);
    div_ovf_c  = funct3[2] && !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    neg_c      = (funct3 == F_REM) ? sa_c : (sa_c ^ sb_c);
  end

  // One iteration: hi accumulates (mul) or holds the partial remainder (div);
  // lo shifts out multiplier digits or shifts in quotient bits.
  logic [PW-1:0]   part_c, sum_c;
  logic [XLEN:0]   rem_sh_c, rem_sub_c;
  logic            div_ge_c;
  logic [XLEN-1:0] hi_nx_c, lo_nx_c;

  always_comb begin
    part_c    = PW'(mcand) * PW'(lo[MUL_BITS-1:0]);
    sum_c     = PW'(hi) + part_c;
    rem_sh_c  = {hi, lo[XLEN-1]};
    rem_sub_c = rem_sh_c - {1'b0, mcand};
    div_ge_c  = rem_sh_c >= {1'b0, mcand};
    hi_nx_c   = sum_c[PW-1:MUL_BITS];
    lo_nx_c   = {sum_c[MUL_BITS-1:0], lo[XLEN-1:MUL_BITS]};
    if (op[2]) begin
      hi_nx_c = div_ge_c ? XLEN'(rem_sub_c) : XLEN'(rem_sh_c);
      lo_nx_c = {lo[XLEN-2:0], div_ge_c};
    end
  end

  // Sign fixup and half/quotient/remainder selection
  logic [2*XLEN-1:0] prod_c, prod_f_c;
  logic [XLEN-1:0]   div_sel_c, res_c;

  always_comb begin
    prod_c    = {hi, lo};
    prod_f_c  = neg ? -prod_c : prod_c;
    div_sel_c = op[1] ? hi : lo;
    res_c     = prod_f_c[2*XLEN-1:XLEN];
    if (op[2]) begin
      res_c = neg ? -div_sel_c : div_sel_c;
    end else if (op == F_MUL) begin
      res_c = prod_f_c[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      tag_out   <= '0;
      op        <= '0;
      tag_q     <= '0;
      neg       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      cnt       <= '0;
    end else if (kill) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op       <= funct3;
            tag_q    <= tag_in;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            neg      <= 1'b0;
            hi       <= '0;
            // Special cases preload quotient (lo) and remainder (hi) directly
            if (div_zero_c) begin
              hi    <= rs1;
              lo    <= '1;
              state <= DONE;
            end else if (div_ovf_c) begin
              lo    <= rs1;
              state <= DONE;
            end else if (funct3[2]) begin
              neg   <= neg_c;
              lo    <= mag_a_c;
              mcand <= mag_b_c;
              cnt   <= CNT_W'(XLEN);
              state <= CALC;
            end else begin
              neg   <= neg_c;
              lo    <= mag_b_c;
              mcand <= mag_a_c;
              cnt   <= CNT_W'(MUL_STEPS);
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi  <= hi_nx_c;
          lo  <= lo_nx_c;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle applies the fixup; then hold until retired
          if (!out_valid) begin
            out_valid <= 1'b1;
            result    <= res_c;
            tag_out   <= tag_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: MUL_BITS=1 and MUL_BITS=4 instances,
// vector table plus hand-written handshake/kill/reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, kill, out_ready, sel;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  tag_in;

  logic        ir1, ov1, bz1, ir4, ov4, bz4;
  logic [31:0] res1, res4;
  logic [4:0]  tg1, tg4;

  logic        m_ready, m_valid, m_busy;
  logic [31:0] m_res;
  logic [4:0]  m_tag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
  } exp_t;

  typedef struct {
    bit          s;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  t;
    logic [31:0] r;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_BITS(1), .TAG_W(5)) u_mb1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(ir1),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .tag_in(tag_in), .kill(kill),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .tag_out(tg1), .busy(bz1)
  );

  muldiv_unit #(.XLEN(32), .MUL_BITS(4), .TAG_W(5)) u_mb4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(ir4),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .tag_in(tag_in), .kill(kill),
    .out_valid(ov4), .out_ready(out_ready), .result(res4), .tag_out(tg4), .busy(bz4)
  );

  always_comb begin
    m_ready = sel ? ir4  : ir1;
    m_valid = sel ? ov4  : ov1;
    m_busy  = sel ? bz4  : bz1;
    m_res   = sel ? res4 : res1;
    m_tag   = sel ? tg4  : tg1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sbv;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] da, db, q;
    logic [31:0]        r;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    da  = a;
    db  = b;
    r   = '0;
    case (f3)
      3'd0: begin p = ua * ub;  r = p[31:0];  end
      3'd1: begin p = sa * sbv; r = p[63:32]; end
      3'd2: begin p = sa * ub;  r = p[63:32]; end
      3'd3: begin p = ua * ub;  r = p[63:32]; end
      default: begin
        if (b == 32'h0) begin
          r = f3[1] ? a : 32'hFFFF_FFFF;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = f3[1] ? 32'h0 : a;
        end else if (!f3[0]) begin
          q = f3[1] ? (da % db) : (da / db);
          r = q;
        end else begin
          r = f3[1] ? (a % b) : (a / b);
        end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input bit s, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && (b == 32'h0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    if (f3[2]) return 33;
    return s ? 9 : 33;
  endfunction

  task automatic add_vec(input bit s, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t, input logic [31:0] r,
                         input int lat);
    vec_t v;
    v.s = s; v.f3 = f3; v.a = a; v.b = b; v.t = t; v.r = r; v.lat = lat;
    vt.push_back(v);
  endtask

  // Issue one op, wait (bounded) for its result, check against scoreboard head
  task automatic run_op(input bit s, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t,
                        input logic [31:0] er, input int el);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    sel = s;
    #1;
    chk("in_ready_before_issue", 32'(m_ready), 32'd1);
    in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; tag_in = t;
    @(posedge clk); #1;
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; tag_in = 5'($urandom);
    e.res = er; e.tag = t; e.lat = el;
    sb.push_back(e);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (m_valid) seen = 1'b1;
    end
    chk("out_valid_seen", 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      chk("latency", 32'(lat), 32'(e.lat));
      chk("result", m_res, e.res);
      chk("tag", 32'(m_tag), 32'(e.tag));
      @(posedge clk); #1;
      chk("out_valid_after_hs", 32'(m_valid), 32'd0);
      chk("in_ready_after_hs", 32'(m_ready), 32'd1);
    end
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    bit any;
    any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      any = any | ov1 | ov4;
    end
    chk(name, 32'(any), 32'd0);
  endtask

  initial begin
    int   lat;
    bit   seen;
    exp_t e;

    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1; sel = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov1 | ov4), 32'd0);
    chk("rst_result", res1 | res4, 32'd0);
    chk("rst_tag", 32'(tg1 | tg4), 32'd0);
    chk("rst_busy", 32'(bz1 | bz4), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(ir1 & ir4), 32'd1);

    // Directed vectors
    add_vec(0, 3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    add_vec(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33);
    add_vec(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33);
    add_vec(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33);
    add_vec(1, 3'b000, 32'd7,         32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB, 9);
    add_vec(1, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 9);
    add_vec(1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 9);
    add_vec(1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, 9);
    add_vec(0, 3'b100, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFD, 33);
    add_vec(0, 3'b110, 32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFF, 33);
    add_vec(0, 3'b101, 32'd100,       32'd7,         5'd15, 32'd14,        33);
    add_vec(0, 3'b111, 32'd100,       32'd7,         5'd16, 32'd2,         33);
    add_vec(1, 3'b100, 32'hFFFF_FFF9, 32'd2,         5'd17, 32'hFFFF_FFFD, 33);
    add_vec(0, 3'b101, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1);
    add_vec(0, 3'b111, 32'd5,         32'd0,         5'd19, 32'd5,         1);
    add_vec(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1);
    add_vec(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,         1);
    add_vec(1, 3'b100, 32'hFFFF_FFF9, 32'd0,         5'd22, 32'hFFFF_FFFF, 1);
    add_vec(1, 3'b110, 32'hFFFF_FFF9, 32'd0,         5'd23, 32'hFFFF_FFF9, 1);

    for (int i = 0; i < vt.size(); i++)
      run_op(vt[i].s, vt[i].f3, vt[i].a, vt[i].b, vt[i].t, vt[i].r, vt[i].lat);

    // Random ops against the reference model
    for (int i = 0; i < 16; i++) begin
      bit          s;
      logic [2:0]  f3;
      logic [31:0] a, b;
      s  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(s, f3, a, b, 5'(i), model(f3, a, b), exp_lat(s, f3, a, b));
    end

    // Backpressure in DONE, and no accept on the handshake cycle
    @(negedge clk);
    sel = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; tag_in = 5'd25;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.res = 32'd14; e.tag = 5'd25; e.lat = 33;
    sb.push_back(e);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (m_valid) seen = 1'b1;
    end
    e = sb.pop_front();
    chk("bp_latency", 32'(lat), 32'(e.lat));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(m_valid), 32'd1);
      chk("bp_result", m_res, e.res);
      chk("bp_tag", 32'(m_tag), 32'(e.tag));
      chk("bp_in_ready", 32'(m_ready), 32'd0);
      chk("bp_busy", 32'(m_busy), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_hs_valid", 32'(m_valid), 32'd0);
    chk("bp_hs_in_ready", 32'(m_ready), 32'd1);
    chk("bp_hs_no_accept", 32'(m_busy), 32'd0);

    // Kill five cycles into a DIV
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b100; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; tag_in = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", 32'(m_busy), 32'd0);
    chk("kill_in_ready", 32'(m_ready), 32'd1);
    chk("kill_valid", 32'(m_valid), 32'd0);
    watch_quiet("kill_no_output", 40);
    run_op(0, 3'b000, 32'd3, 32'd4, 5'd4, 32'd12, 33);

    // Kill in IDLE blocks the accept
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; funct3 = 3'b000; rs1 = 32'd1; rs2 = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_idle_no_accept", 32'(m_busy), 32'd0);

    // Kill together with out_ready in DONE wins over the handshake
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; funct3 = 3'b101; rs1 = 32'd5; rs2 = 32'd0; tag_in = 5'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("kill_done_valid_pre", 32'(m_valid), 32'd1);
    @(negedge clk); kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_done_valid", 32'(m_valid), 32'd0);
    chk("kill_done_busy", 32'(m_busy), 32'd0);
    watch_quiet("kill_done_quiet", 5);

    // Reset mid-CALC
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; tag_in = 5'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_result", m_res, 32'd0);
    chk("mid_rst_tag", 32'(m_tag), 32'd0);
    chk("mid_rst_busy", 32'(m_busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(m_ready), 32'd1);
    watch_quiet("mid_rst_quiet", 40);
    run_op(1, 3'b011, 32'hFFFF_FFFF, 32'd2, 5'd1, 32'd1, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
